// File: rtl/panda_mem_loader_if.sv
// Bus interface for panda_mem_loader: load-control inputs, the input data
// stream and the memory write port. Port names are seen from the loader
// (slave) side. With PANDA_MEM_LOADER_CHECKSUM_EN defined the interface
// also carries checksum_o.
interface panda_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 11,
  parameter int NB_MEM     = 7
);
  logic                  start_i;
  logic [2:0]            mem_sel_i;
  logic [CNT_WIDTH-1:0]  len_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [NB_MEM-1:0]     mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  busy_o;
  logic                  done_o;
`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_o;

  modport slave (
    input  start_i, mem_sel_i, len_i, base_addr_i, data_i, valid_i,
    output ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cnt_o, busy_o, done_o,
    output checksum_o
  );
  modport master (
    output start_i, mem_sel_i, len_i, base_addr_i, data_i, valid_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cnt_o, busy_o, done_o,
    input  checksum_o
  );
`else
  modport slave (
    input  start_i, mem_sel_i, len_i, base_addr_i, data_i, valid_i,
    output ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cnt_o, busy_o, done_o
  );
  modport master (
    output start_i, mem_sel_i, len_i, base_addr_i, data_i, valid_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_wdata_o, cnt_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/panda_mem_loader.sv
// panda_mem_loader: engine-side receiver of the PANDA memory-load protocol.
// Accepts a stream of words after a start pulse and writes them, through a
// registered one-hot write port, into the selected PANDA memory starting at
// base_addr. mem_sel 7 drains the stream without writing.
// Optional feature macro: PANDA_MEM_LOADER_CHECKSUM_EN adds checksum_o, a
// running XOR of the words accepted in the current/last transfer.
module panda_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 11,
  parameter int NB_MEM     = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  panda_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            sel_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB_MEM-1:0]     we_q;
  logic                  hs_s;
  logic                  last_s;
  logic                  start_ok_s;

  // Decode a memory select into its one-hot write enable; NULL (or any
  // select beyond the memory count) gives no enable at all.
  function automatic logic [NB_MEM-1:0] sel_onehot(input logic [2:0] sel);
    logic [NB_MEM-1:0] oh;
    oh = '0;
    if (32'(sel) < NB_MEM) begin
      oh = NB_MEM'(1) << sel;
    end else begin
      oh = '0;
    end
    return oh;
  endfunction

  // A word is taken only in LOAD; cnt never passes len so it saturates there.
  assign hs_s       = bus.valid_i && (state_q == LOAD) && (cnt_q != len_q);
  assign last_s     = hs_s && ((cnt_q + CNT_WIDTH'(1)) == len_q);
  assign start_ok_s = bus.start_i && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = (bus.len_i == '0) ? DONE : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Parameter latch, word counter and registered memory write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= 3'd0;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (clear_i) begin
      // The write that would have been issued this edge is dropped.
      cnt_q <= '0;
      we_q  <= '0;
    end else begin
      we_q <= '0;
      if (start_ok_s) begin
        sel_q  <= bus.mem_sel_i;
        len_q  <= bus.len_i;
        base_q <= bus.base_addr_i;
        cnt_q  <= '0;
      end else if (hs_s) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
        // In drain mode address/data keep their last written values.
        if (sel_q != 3'd7) begin
          we_q    <= sel_onehot(sel_q);
          addr_q  <= base_q + ADDR_WIDTH'(cnt_q);
          wdata_q <= bus.data_i;
        end
      end
    end
  end

`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Running XOR of accepted words, restarted by every accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if (clear_i) begin
      csum_q <= '0;
    end else if (start_ok_s) begin
      csum_q <= '0;
    end else if (hs_s) begin
      csum_q <= csum_q ^ bus.data_i;
    end
  end

  assign bus.checksum_o = csum_q;
`endif

  assign bus.ready_o     = (state_q == LOAD);
  assign bus.busy_o      = (state_q == LOAD);
  assign bus.done_o      = (state_q == DONE);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.cnt_o       = cnt_q;

endmodule

// File: tb/tb_panda_mem_loader.sv
// Self-checking bench for panda_mem_loader. Inputs are driven and outputs
// sampled on the falling clock edge. The expected write stream is derived
// from the transfer rules: word k of a transfer lands at (base+k) mod 2^16
// in memory sel, one cycle after it is accepted.
module tb_panda_mem_loader;
  logic clk;
  logic rst_n;
  logic clear;

  panda_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CNT_WIDTH(11), .NB_MEM(7)) bus ();

  panda_mem_loader dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_addr = 16'h0;
  logic [31:0] last_data = 32'h0;

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    bus.start_i = 1'b0; bus.mem_sel_i = 3'd0; bus.len_i = 11'd0;
    bus.base_addr_i = 16'h0; bus.data_i = 32'h0; bus.valid_i = 1'b0;
    #7;
    checks++; if ({bus.ready_o, bus.busy_o, bus.done_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.ready_o, bus.busy_o, bus.done_o}); end
    checks++; if (bus.mem_we_o !== 7'd0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we_o); end
    checks++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== 48'd0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o}); end
    checks++; if (bus.cnt_o !== 11'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt_o); end
    @(negedge clk); rst_n = 1'b1;
    last_addr = 16'h0; last_data = 32'h0;
  endtask

  // One transfer. vmode: 0 valid always, 1 random, 2 pattern 1,0,0,1,0,1.
  // dmode: 0 random data, 1 0xA0+k, 2 1<<k. mid_start: cycle with a stray start (-1 none).
  task automatic run_transfer(input string tag, input logic [2:0] sel, input int len,
                              input logic [15:0] base, input int vmode, input int dmode,
                              input int mid_start);
    int k; int cyc; logic vdrv; logic [31:0] dval;
    logic [6:0] exp_we; logic [15:0] ea; logic [5:0] pat;
`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
    csum = 32'h0;
`endif
    pat = 6'b101001;
    exp_we = 7'd0;
    if (sel != 3'd7) exp_we[sel] = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.mem_sel_i = sel; bus.len_i = 11'(len);
    bus.base_addr_i = base; bus.valid_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.mem_sel_i = 3'($urandom); bus.len_i = 11'($urandom);
    bus.base_addr_i = 16'($urandom);
    if (len == 0) begin
      checks++; if ({bus.done_o, bus.ready_o, bus.busy_o} !== 3'b100) begin errors++; $display("FAIL %s zero_done: got %b want 100", tag, {bus.done_o, bus.ready_o, bus.busy_o}); end
      checks++; if (bus.mem_we_o !== 7'd0) begin errors++; $display("FAIL %s zero_we: got %b want 0", tag, bus.mem_we_o); end
      @(negedge clk);
      checks++; if ({bus.done_o, bus.mem_we_o} !== 8'd0) begin errors++; $display("FAIL %s zero_after: got %b want 0", tag, {bus.done_o, bus.mem_we_o}); end
      checks++; if (bus.cnt_o !== 11'd0) begin errors++; $display("FAIL %s zero_cnt: got %0d want 0", tag, bus.cnt_o); end
      return;
    end
    k = 0; cyc = 0;
    while (k < len && cyc < 400) begin
      checks++; if ({bus.ready_o, bus.busy_o, bus.done_o} !== 3'b110) begin errors++; $display("FAIL %s load_flags: got %b want 110", tag, {bus.ready_o, bus.busy_o, bus.done_o}); end
      checks++; if (bus.cnt_o !== 11'(k)) begin errors++; $display("FAIL %s cnt: got %0d want %0d", tag, bus.cnt_o, k); end
      if (vmode == 0) vdrv = 1'b1;
      else if (vmode == 1) vdrv = 1'($urandom_range(0, 1));
      else vdrv = pat[cyc % 6];
      if (dmode == 1) dval = 32'hA0 + 32'(k);
      else if (dmode == 2) dval = 32'd1 << k;
      else dval = $urandom;
      bus.valid_i = vdrv;
      bus.data_i = vdrv ? dval : $urandom;
      if (cyc == mid_start) begin
        bus.start_i = 1'b1; bus.mem_sel_i = 3'd0; bus.len_i = 11'd1; bus.base_addr_i = 16'h0;
      end
      @(negedge clk);
      bus.start_i = 1'b0; bus.valid_i = 1'b0;
      if (vdrv) begin
        ea = base + 16'(k);
        k++;
`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
        csum = csum ^ dval;
`endif
        checks++; if (bus.mem_we_o !== exp_we) begin errors++; $display("FAIL %s we: got %b want %b", tag, bus.mem_we_o, exp_we); end
        if (sel != 3'd7) begin
          last_addr = ea; last_data = dval;
        end
        checks++; if (bus.mem_addr_o !== last_addr) begin errors++; $display("FAIL %s addr: got %h want %h", tag, bus.mem_addr_o, last_addr); end
        checks++; if (bus.mem_wdata_o !== last_data) begin errors++; $display("FAIL %s wdata: got %h want %h", tag, bus.mem_wdata_o, last_data); end
        if (k == len) begin
          checks++; if ({bus.done_o, bus.ready_o, bus.busy_o} !== 3'b100) begin errors++; $display("FAIL %s done: got %b want 100", tag, {bus.done_o, bus.ready_o, bus.busy_o}); end
          checks++; if (bus.cnt_o !== 11'(len)) begin errors++; $display("FAIL %s done_cnt: got %0d want %0d", tag, bus.cnt_o, len); end
`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
          checks++; if (bus.checksum_o !== csum) begin errors++; $display("FAIL %s checksum: got %h want %h", tag, bus.checksum_o, csum); end
`endif
        end
      end else begin
        checks++; if ({bus.mem_we_o, bus.done_o} !== 8'd0) begin errors++; $display("FAIL %s gap_we: got %b want 0", tag, {bus.mem_we_o, bus.done_o}); end
        checks++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== {last_addr, last_data}) begin errors++; $display("FAIL %s gap_hold: got %h want %h", tag, {bus.mem_addr_o, bus.mem_wdata_o}, {last_addr, last_data}); end
      end
      cyc++;
    end
    if (k < len) begin
      checks++; errors++; $display("FAIL %s timeout: got %0d words want %0d", tag, k, len);
    end else begin
      @(negedge clk);
      checks++; if ({bus.done_o, bus.ready_o, bus.busy_o, bus.mem_we_o} !== 10'd0) begin errors++; $display("FAIL %s idle: got %b want 0", tag, {bus.done_o, bus.ready_o, bus.busy_o, bus.mem_we_o}); end
      checks++; if (bus.cnt_o !== 11'(len)) begin errors++; $display("FAIL %s hold_cnt: got %0d want %0d", tag, bus.cnt_o, len); end
    end
  endtask

  task automatic test_basic();
    run_transfer("basic", 3'd4, 4, 16'h0100, 0, 1, -1);
    checks++; if (last_addr !== 16'h0103) begin errors++; $display("FAIL basic_last_addr: got %h want 0103", last_addr); end
  endtask

  task automatic test_backpressure();
    run_transfer("gaps", 3'd1, 3, 16'h2000, 2, 0, -1);
  endtask

  task automatic test_zero_and_null();
    run_transfer("zero", 3'd2, 0, 16'h0040, 0, 0, -1);
    run_transfer("null", 3'd7, 5, 16'h0300, 1, 0, -1);
  endtask

  task automatic test_wrap_ignored_start();
    run_transfer("wrap", 3'd3, 3, 16'hFFFE, 0, 0, 1);
    checks++; if (last_addr !== 16'h0000) begin errors++; $display("FAIL wrap_last_addr: got %h want 0000", last_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_transfer("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                   16'($urandom), 1, 0, int'($urandom_range(0, 6)) - 1);
    end
  endtask

  task automatic test_back_to_back();
    run_transfer("b2b_a", 3'd5, 2, 16'h1000, 0, 0, -1);
    run_transfer("b2b_b", 3'd6, 2, 16'h1100, 0, 0, -1);
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.start_i = 1'b1; bus.mem_sel_i = 3'd2; bus.len_i = 11'd6; bus.base_addr_i = 16'h0500;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.valid_i = 1'b1; bus.data_i = $urandom;
      @(negedge clk);
    end
    checks++; if (bus.cnt_o !== 11'd2) begin errors++; $display("FAIL clear_pre_cnt: got %0d want 2", bus.cnt_o); end
    clear = 1'b1; bus.valid_i = 1'b1; bus.data_i = $urandom;
    @(negedge clk);
    clear = 1'b0; bus.valid_i = 1'b0;
    checks++; if ({bus.ready_o, bus.busy_o, bus.done_o, bus.mem_we_o} !== 10'd0) begin errors++; $display("FAIL clear_flags: got %b want 0", {bus.ready_o, bus.busy_o, bus.done_o, bus.mem_we_o}); end
    checks++; if (bus.cnt_o !== 11'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", bus.cnt_o); end
    last_addr = 16'h0501; last_data = bus.mem_wdata_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.done_o, bus.ready_o} !== 2'b00) begin errors++; $display("FAIL clear_no_done: got %b want 00", {bus.done_o, bus.ready_o}); end
    end
    checks++; if (bus.mem_addr_o !== last_addr) begin errors++; $display("FAIL clear_addr_hold: got %h want %h", bus.mem_addr_o, last_addr); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start_i = 1'b1; bus.mem_sel_i = 3'd0; bus.len_i = 11'd6; bus.base_addr_i = 16'h0700;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.valid_i = 1'b1; bus.data_i = $urandom | 32'h1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.ready_o, bus.busy_o, bus.done_o, bus.mem_we_o} !== 10'd0) begin errors++; $display("FAIL arst_flags: got %b want 0", {bus.ready_o, bus.busy_o, bus.done_o, bus.mem_we_o}); end
    checks++; if ({bus.mem_addr_o, bus.mem_wdata_o, bus.cnt_o} !== 59'd0) begin errors++; $display("FAIL arst_data: got %h want 0", {bus.mem_addr_o, bus.mem_wdata_o, bus.cnt_o}); end
    bus.valid_i = 1'b0;
    last_addr = 16'h0; last_data = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.done_o, bus.ready_o, bus.mem_we_o} !== 9'd0) begin errors++; $display("FAIL arst_after: got %b want 0", {bus.done_o, bus.ready_o, bus.mem_we_o}); end
    end
  endtask

`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    run_transfer("csum", 3'd0, 3, 16'h0010, 0, 2, -1);
    checks++; if (bus.checksum_o !== 32'h7) begin errors++; $display("FAIL checksum_hold: got %h want 00000007", bus.checksum_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_and_null();
    test_wrap_ignored_start();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    test_basic();
`ifdef PANDA_MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
